// File: rtl/uart_poll_master.sv
// uart_poll_master
// RS485 half-duplex poll initiator for one sensor channel. A start pulse
// drives the bus, sends one request byte (8N1), releases the bus and then
// collects a fixed-length response frame. Each byte goes to a downstream
// frame buffer via rx_data/rx_addr/rx_we.
//
// Ports:
//   clk80MHz   system clock, all logic on the rising edge
//   rst        synchronous reset, active-high
//   start      single-cycle poll request, accepted only in IDLE
//   req_byte   request byte, captured when start is accepted
//   UART_RX    asynchronous serial input, idle high
//   UART_TX    serial output, idle high
//   UART_dTX   RS485 driver enable (1 = transmitting)
//   UART_dRX   RS485 receiver disable (1 = receiver off)
//   rx_data    received byte
//   rx_addr    byte index within the frame
//   rx_we      one-cycle write strobe for rx_data/rx_addr
//   frame_done one-cycle pulse after a complete error-free frame
//   frame_err  one-cycle pulse on timeout or framing error
//   busy       high in every state except IDLE
module uart_poll_master #(
    parameter int CLKS_PER_BIT = 34,
    parameter int N_BYTES      = 20,
    parameter int RESP_TIMEOUT = 64,
    parameter int GAP_TIMEOUT  = 16
) (
    input  logic       clk80MHz,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] req_byte,
    input  logic       UART_RX,
    output logic       UART_TX,
    output logic       UART_dTX,
    output logic       UART_dRX,
    output logic [7:0] rx_data,
    output logic [4:0] rx_addr,
    output logic       rx_we,
    output logic       frame_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TMAX = (RESP_TIMEOUT > GAP_TIMEOUT) ? RESP_TIMEOUT : GAP_TIMEOUT;
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {S_IDLE, S_TX, S_RX_WAIT, S_RX_BYTE, S_DONE, S_ERR} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;        // cycle count within a bit
    logic [3:0]    bit_reg, bit_next;        // bit position within a frame
    logic [TW-1:0] to_reg, to_next;          // elapsed bit-times while waiting
    logic [4:0]    idx_reg, idx_next;        // index of the next byte to receive
    logic [7:0]    tx_shift_reg, tx_shift_next;
    logic [7:0]    rx_shift_reg, rx_shift_next;
    logic          tx_reg, tx_next;
    logic          dtx_reg, dtx_next;
    logic          drx_reg, drx_next;
    logic [7:0]    rx_data_reg, rx_data_next;
    logic [4:0]    rx_addr_reg, rx_addr_next;
    logic          rx_we_reg, rx_we_next;

    // [0] metastability flop, [1] synchronised line, [2] previous synchronised value
    logic [2:0]    rx_pipe_reg;
    logic          rx_sync;
    logic          rx_fall;
    logic [TW-1:0] to_inc;
    logic [TW-1:0] to_limit;

    assign rx_sync  = rx_pipe_reg[1];
    assign rx_fall  = rx_pipe_reg[2] & ~rx_pipe_reg[1];
    assign to_inc   = to_reg + TW'(1);
    assign to_limit = (idx_reg == 5'd0) ? TW'(RESP_TIMEOUT) : TW'(GAP_TIMEOUT);

    always_ff @(posedge clk80MHz) begin
        if (rst) begin
            rx_pipe_reg <= 3'b111;
        end else begin
            rx_pipe_reg <= {rx_pipe_reg[1:0], UART_RX};
        end
    end

    always_ff @(posedge clk80MHz) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            to_reg       <= '0;
            idx_reg      <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            tx_reg       <= 1'b1;
            dtx_reg      <= 1'b0;
            drx_reg      <= 1'b0;
            rx_data_reg  <= '0;
            rx_addr_reg  <= '0;
            rx_we_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_reg      <= bit_next;
            to_reg       <= to_next;
            idx_reg      <= idx_next;
            tx_shift_reg <= tx_shift_next;
            rx_shift_reg <= rx_shift_next;
            tx_reg       <= tx_next;
            dtx_reg      <= dtx_next;
            drx_reg      <= drx_next;
            rx_data_reg  <= rx_data_next;
            rx_addr_reg  <= rx_addr_next;
            rx_we_reg    <= rx_we_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_next      = bit_reg;
        to_next       = to_reg;
        idx_next      = idx_reg;
        tx_shift_next = tx_shift_reg;
        rx_shift_next = rx_shift_reg;
        tx_next       = tx_reg;
        dtx_next      = dtx_reg;
        drx_next      = drx_reg;
        rx_data_next  = rx_data_reg;
        rx_addr_next  = rx_addr_reg;
        rx_we_next    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next    = S_TX;
                    tx_shift_next = req_byte;
                    tx_next       = 1'b0;
                    dtx_next      = 1'b1;
                    drx_next      = 1'b1;
                    cnt_next      = '0;
                    bit_next      = '0;
                    idx_next      = '0;
                    rx_addr_next  = '0;
                end
            end

            S_TX: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next = '0;
                    if (bit_reg == 4'd9) begin
                        state_next = S_RX_WAIT;
                        tx_next    = 1'b1;
                        dtx_next   = 1'b0;
                        drx_next   = 1'b0;
                        to_next    = '0;
                    end else begin
                        // Shifting in ones makes the stop bit fall out after the 8 data bits
                        bit_next      = bit_reg + 4'd1;
                        tx_next       = tx_shift_reg[0];
                        tx_shift_next = {1'b1, tx_shift_reg[7:1]};
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            S_RX_WAIT: begin
                // A start edge wins over a timeout reached in the same cycle
                if (rx_fall) begin
                    state_next = S_RX_BYTE;
                    cnt_next   = '0;
                    bit_next   = '0;
                end else if (cnt_reg == BIT_LAST) begin
                    cnt_next = '0;
                    to_next  = to_inc;
                    if (to_inc == to_limit) begin
                        state_next = S_ERR;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            S_RX_BYTE: begin
                if (bit_reg == 4'd10) begin
                    // Second half of the stop bit: the gap timer starts at its
                    // end, but a start edge arriving first is taken directly.
                    if (idx_reg == 5'(N_BYTES)) begin
                        state_next = S_DONE;
                    end else if (rx_fall) begin
                        cnt_next = '0;
                        bit_next = '0;
                    end else if (cnt_reg == HALF_LAST) begin
                        state_next = S_RX_WAIT;
                        cnt_next   = '0;
                        to_next    = '0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end else if (bit_reg == 4'd0) begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_next = '0;
                        if (rx_sync) begin
                            // Glitch: resume waiting with the elapsed bit-times kept
                            state_next = S_RX_WAIT;
                        end else begin
                            bit_next = 4'd1;
                        end
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end else begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_next = '0;
                        if (bit_reg == 4'd9) begin
                            if (!rx_sync) begin
                                state_next = S_ERR;
                            end else begin
                                rx_we_next   = 1'b1;
                                rx_data_next = rx_shift_reg;
                                rx_addr_next = idx_reg;
                                idx_next     = idx_reg + 5'd1;
                                bit_next     = 4'd10;
                            end
                        end else begin
                            rx_shift_next = {rx_sync, rx_shift_reg[7:1]};
                            bit_next      = bit_reg + 4'd1;
                        end
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end

            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign UART_TX    = tx_reg;
    assign UART_dTX   = dtx_reg;
    assign UART_dRX   = drx_reg;
    assign rx_data    = rx_data_reg;
    assign rx_addr    = rx_addr_reg;
    assign rx_we      = rx_we_reg;
    assign frame_done = (state_reg == S_DONE);
    assign frame_err  = (state_reg == S_ERR);
    assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_poll_master.sv
// Testbench for uart_poll_master. A protocol-level model (request frame
// timing, responder byte schedule, frame end events) is checked against the
// DUT on every cycle, plus literal checks of key counts and delays.
module tb_uart_poll_master;

    localparam int CPB  = 34;
    localparam int NB   = 20;
    localparam int RESP = 64;
    localparam int GAP  = 16;
    // Line changes reach the receiver logic through a 2-flop synchroniser
    localparam int SYNC = 2;

    logic       clk80MHz = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] req_byte = 8'h00;
    logic       UART_RX = 1'b1;
    logic       UART_TX, UART_dTX, UART_dRX;
    logic [7:0] rx_data;
    logic [4:0] rx_addr;
    logic       rx_we, frame_done, frame_err, busy;

    uart_poll_master #(
        .CLKS_PER_BIT(CPB), .N_BYTES(NB), .RESP_TIMEOUT(RESP), .GAP_TIMEOUT(GAP)
    ) dut (
        .clk80MHz(clk80MHz), .rst(rst), .start(start), .req_byte(req_byte),
        .UART_RX(UART_RX), .UART_TX(UART_TX), .UART_dTX(UART_dTX), .UART_dRX(UART_dRX),
        .rx_data(rx_data), .rx_addr(rx_addr), .rx_we(rx_we),
        .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
    );

    always #6 clk80MHz = ~clk80MHz;

    int cyc = 0;
    always @(posedge clk80MHz) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Model state
    typedef struct { int due; logic [4:0] addr; logic [7:0] data; } wr_t;
    wr_t        exp_q[$];
    int         tx_acc   = -100000;   // cycle the last accepted start was sampled
    logic [7:0] tx_req   = 8'h00;
    int         busy_end = -1;
    int         exp_done = -1;
    int         exp_err  = -1;
    int         rsp_idx  = 0;
    bit         chk_en   = 1'b0;

    // Observation counters
    int we_cnt, done_cnt, err_cnt, last_addr, err_seen, dtx_hi;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk80MHz) begin : compare
        int   k;
        bit   in_tx;
        logic exp_tx;
        if (chk_en) begin
            in_tx  = (cyc >= tx_acc) && (cyc < tx_acc + 10*CPB);
            exp_tx = 1'b1;
            if (in_tx) begin
                k = (cyc - tx_acc) / CPB;
                if (k == 0) exp_tx = 1'b0;
                else if (k <= 8) exp_tx = tx_req[k-1];
            end
            chk("UART_TX", UART_TX, exp_tx);
            chk("UART_dTX", UART_dTX, in_tx);
            chk("UART_dRX", UART_dRX, in_tx);
            chk("busy", busy, (cyc >= tx_acc) && (cyc <= busy_end));
            chk("frame_done", frame_done, cyc == exp_done);
            chk("frame_err", frame_err, cyc == exp_err);
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                chk("rx_we", rx_we, 1);
                chk("rx_addr", rx_addr, exp_q[0].addr);
                chk("rx_data", rx_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end else begin
                chk("rx_we_quiet", rx_we, 0);
            end
            if (rx_we === 1'b1) begin
                we_cnt++;
                last_addr = rx_addr;
                $display("[TB] cyc %0d write addr %0d data 0x%02h", cyc, rx_addr, rx_data);
            end
            if (frame_done === 1'b1) begin
                done_cnt++;
                $display("[TB] cyc %0d frame_done", cyc);
            end
            if (frame_err === 1'b1) begin
                err_cnt++;
                err_seen = cyc;
                $display("[TB] cyc %0d frame_err", cyc);
            end
            if (UART_dTX === 1'b1) dtx_hi++;
        end
    end

    task tick();
        @(posedge clk80MHz);
        #2;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic clr_counts();
        we_cnt = 0; done_cnt = 0; err_cnt = 0; last_addr = -1; err_seen = -1; dtx_hi = 0;
    endtask

    task automatic do_start(input logic [7:0] b, input bit accept);
        req_byte = b;
        start    = 1'b1;
        if (accept) begin
            tx_acc   = cyc + 1;
            tx_req   = b;
            busy_end = 1000000;
            exp_done = -1;
            exp_err  = -1;
            rsp_idx  = 0;
        end
        $display("[TB] cyc %0d start req 0x%02h", cyc, b);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_release();
        wait_until(tx_acc + 10*CPB);
    endtask

    task automatic idle_bits(input int n);
        UART_RX = 1'b1;
        repeat (n*CPB) tick();
    endtask

    // Sends one 8N1 byte; the write is due once the stop-bit centre has
    // crossed the synchroniser, and is registered one cycle later.
    task automatic send_byte(input logic [7:0] d, input bit stop_ok, output int e1);
        wr_t w;
        e1 = cyc + 1;
        if (stop_ok) begin
            w.due  = e1 + 9*CPB + CPB/2 + SYNC;
            w.addr = 5'(rsp_idx);
            w.data = d;
            exp_q.push_back(w);
            rsp_idx++;
            if (rsp_idx == NB) begin
                exp_done = w.due + 1;
                busy_end = w.due + 1;
            end
        end else begin
            exp_err  = e1 + 9*CPB + CPB/2 + SYNC;
            busy_end = exp_err;
        end
        UART_RX = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            UART_RX = d[i];
            repeat (CPB) tick();
        end
        UART_RX = stop_ok;
        repeat (CPB) tick();
        UART_RX = 1'b1;
    endtask

    function automatic logic [7:0] pat(input int k);
        return (k == 0) ? 8'h07 : 8'(10*k);
    endfunction

    task automatic respond(input int first, input int n, input int bad, input int gap_bits,
                           output int last_e1);
        int e;
        e = 0;
        for (int k = first; k < first + n; k++) begin
            send_byte(pat(k), k != bad, e);
            if (k < first + n - 1) idle_bits(gap_bits);
        end
        last_e1 = e;
    endtask

    initial begin : watchdog
        repeat (95000) @(posedge clk80MHz);
        fails++;
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : main
        logic [9:0] s1_frame;
        int e;
        s1_frame = 10'b1010110100;   // stop, 0x5A LSB first, start
        clr_counts();
        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_UART_TX", UART_TX, 1);
        chk("rst_UART_dTX", UART_dTX, 0);
        chk("rst_UART_dRX", UART_dRX, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_addr", rx_addr, 0);
        chk("rst_rx_we", rx_we, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        repeat (4) tick();

        // 1: normal poll
        clr_counts();
        do_start(8'h5A, 1);
        for (int b = 0; b < 10; b++) begin
            wait_until(tx_acc + b*CPB + CPB/2);
            chk("s1_tx_bit", UART_TX, s1_frame[b]);
        end
        wait_release();
        idle_bits(30);
        respond(0, NB, -1, 10, e);
        wait_until(busy_end + 3);
        chk("s1_dtx_cycles", dtx_hi, 340);
        chk("s1_writes", we_cnt, 20);
        chk("s1_last_addr", last_addr, 19);
        chk("s1_done_cnt", done_cnt, 1);
        chk("s1_err_cnt", err_cnt, 0);

        // 2: no response
        clr_counts();
        do_start(8'h81, 1);
        exp_err  = tx_acc + 10*CPB + RESP*CPB;
        busy_end = exp_err;
        wait_until(exp_err + 4);
        chk("s2_err_delay", err_seen - (tx_acc + 10*CPB), 2176);
        chk("s2_writes", we_cnt, 0);
        chk("s2_err_cnt", err_cnt, 1);

        // 3: framing error on byte 3
        clr_counts();
        do_start(8'h33, 1);
        wait_release();
        idle_bits(5);
        respond(0, 4, 3, 4, e);
        wait_until(busy_end + 3);
        chk("s3_writes", we_cnt, 3);
        chk("s3_last_addr", last_addr, 2);
        chk("s3_err_cnt", err_cnt, 1);
        chk("s3_done_cnt", done_cnt, 0);

        // 4: gap timeout after byte 9
        clr_counts();
        do_start(8'hF0, 1);
        wait_release();
        idle_bits(5);
        respond(0, 10, -1, 4, e);
        exp_err  = e + 10*CPB + GAP*CPB + SYNC;
        busy_end = exp_err;
        wait_until(exp_err + 4);
        chk("s4_err_delay", err_seen - (e + 10*CPB), 546);
        chk("s4_writes", we_cnt, 10);
        chk("s4_last_addr", last_addr, 9);
        chk("s4_err_cnt", err_cnt, 1);

        // 5: glitch in RX_WAIT, start ignored while receiving
        clr_counts();
        do_start(8'h3C, 1);
        wait_release();
        idle_bits(10);
        UART_RX = 1'b0;
        repeat (5) tick();
        UART_RX = 1'b1;
        idle_bits(20);
        respond(0, 1, -1, 2, e);
        idle_bits(2);
        fork
            send_byte(pat(1), 1'b1, e);
            begin
                repeat (100) tick();
                do_start(8'hC3, 0);
            end
        join
        idle_bits(2);
        respond(2, NB - 2, -1, 2, e);
        wait_until(busy_end + 3);
        chk("s5_writes", we_cnt, 20);
        chk("s5_done_cnt", done_cnt, 1);
        chk("s5_err_cnt", err_cnt, 0);
        chk("s5_dtx_cycles", dtx_hi, 340);

        // 6: reset during byte 12, then a clean frame
        clr_counts();
        do_start(8'hA5, 1);
        wait_release();
        idle_bits(5);
        respond(0, 12, -1, 2, e);
        idle_bits(2);
        UART_RX = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            UART_RX = pat(12)[i];
            repeat (CPB) tick();
        end
        repeat (10) tick();
        rst      = 1'b1;
        busy_end = cyc;
        tick();
        rst = 1'b0;
        chk("r6_UART_TX", UART_TX, 1);
        chk("r6_UART_dTX", UART_dTX, 0);
        chk("r6_UART_dRX", UART_dRX, 0);
        chk("r6_rx_data", rx_data, 0);
        chk("r6_rx_addr", rx_addr, 0);
        chk("r6_rx_we", rx_we, 0);
        chk("r6_frame_done", frame_done, 0);
        chk("r6_frame_err", frame_err, 0);
        chk("r6_busy", busy, 0);
        chk("s6_partial_writes", we_cnt, 12);
        idle_bits(3);
        clr_counts();
        do_start(8'h11, 1);
        wait_release();
        idle_bits(5);
        respond(0, NB, -1, 2, e);
        wait_until(busy_end + 3);
        chk("s6_writes", we_cnt, 20);
        chk("s6_last_addr", last_addr, 19);
        chk("s6_done_cnt", done_cnt, 1);
        chk("s6_err_cnt", err_cnt, 0);
        chk("s6_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_poll_master.md
Name: uart_poll_master

Overview:
- RS485 half-duplex poll initiator for one sensor channel, clocked by clk80MHz.
- On a start pulse it drives the bus and transmits one request byte, then releases the bus.
- It then receives a fixed-length response frame (default 20 bytes) and writes each byte into a downstream frame buffer.
- One instance is used per channel (UART 1 / UART 2). It feeds the orbital frame builder.

Parameters:
CLKS_PER_BIT, 34, clk80MHz cycles per UART bit (~2.35 Mbaud)
N_BYTES, 20, bytes per response frame
RESP_TIMEOUT, 64, bit-times allowed from bus release to first start bit
GAP_TIMEOUT, 16, bit-times allowed between the end of one byte's stop bit and the next start bit

Ports:
clk80MHz  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle poll request; ignored unless in IDLE
req_byte  in  8  request byte, latched when start is accepted
UART_RX  in  1  serial receive line, asynchronous, idle high
UART_TX  out  1  serial transmit line, idle high
UART_dTX  out  1  RS485 driver enable, 1 = transmitting
UART_dRX  out  1  RS485 receiver disable, 1 = receiver off (0 = listening)
rx_data  out  8  received byte
rx_addr  out  5  byte index within the frame, 0..N_BYTES-1
rx_we  out  1  single-cycle write strobe for rx_data/rx_addr
frame_done  out  1  single-cycle pulse when N_BYTES are received without error
frame_err  out  1  single-cycle pulse on timeout or framing error
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: UART_TX=1, UART_dTX=0, UART_dRX=0, rx_data=0, rx_addr=0, rx_we=0, frame_done=0, frame_err=0, busy=0, state=IDLE.
- Reset applies on any clock edge with rst high. It aborts any state immediately and takes priority over start.
- UART_RX passes through a 2-flop synchroniser. All RX decisions use the synchronised value.
- States: IDLE, TX, RX_WAIT, RX_BYTE, DONE, ERR.
- IDLE:
  - start=1 latches req_byte.
  - Next cycle: state=TX, UART_dTX=1, UART_dRX=1, busy=1.
- TX:
  - Frame is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.
  - When the stop bit ends: UART_dTX=0 and UART_dRX=0 in the same cycle, state=RX_WAIT, timeout counter cleared.
- RX_WAIT:
  - Counts bit-times.
  - A falling edge of synchronised RX moves to RX_BYTE.
  - Limit is RESP_TIMEOUT for byte 0 and GAP_TIMEOUT for later bytes. Reaching the limit moves to ERR.
  - If a falling edge and the limit occur in the same cycle, the edge wins.
- RX_BYTE:
  - Re-samples the start bit at CLKS_PER_BIT/2. If the sample is high, the edge was a glitch: return to RX_WAIT with the timeout counter preserved.
  - Samples data bits at the centre of each bit, LSB first, then samples the stop bit.
  - Stop bit = 0 → ERR; no write.
  - Stop bit = 1 → rx_we=1 for one cycle with the byte and its index. Then increment the index.
  - If the index reaches N_BYTES → DONE; otherwise → RX_WAIT.
- DONE: frame_done=1 for one cycle, then IDLE.
- ERR: frame_err=1 for one cycle, then IDLE. Bytes already written stay in the buffer.
- rx_addr wraps only via return to IDLE (reset to 0 on the next start). It never exceeds N_BYTES-1.
- Latency:
  - start → UART_TX start-bit edge: 1 cycle.
  - Centre of stop-bit sample → rx_we: 1 cycle.
  - Last rx_we → frame_done: 1 cycle.
- UART_RX activity during TX or IDLE is ignored.

Test Plan:
1. Normal poll: start with req_byte=0x5A; responder waits 30 bit-times, then sends 20 bytes (0x07, 10, 20 … 190) with 10 idle bit-times between bytes → UART_TX shows 0x5A LSB first; UART_dTX/UART_dRX high exactly 10 bit-times then both low; 20 rx_we pulses with addr 0..19 and matching data; frame_done pulses once; frame_err never asserts.
2. No response: start, UART_RX held high → frame_err pulses exactly 64 bit-times after bus release; zero rx_we pulses.
3. Framing error: byte 3 sent with stop bit=0 → rx_we for addr 0..2 only, then frame_err; busy falls 1 cycle later.
4. Gap timeout: responder stops after byte 9 → frame_err 16 bit-times after byte 9's stop bit; the last write is addr 9.
5. Glitch and busy: a 5-cycle low pulse on UART_RX during RX_WAIT gives no rx_we and reception then continues normally; a start pulse during RX_BYTE is ignored, and req_byte changes are not transmitted.
6. Reset mid-frame: rst=1 for 1 cycle during byte 12 → the next cycle all outputs are at reset values; a subsequent start gives a clean frame beginning at addr 0.
